// File: rtl/tt_um_3515_detect_display_ctrl.sv
// Detection event display controller.
// Counts rising edges of a detector level in BCD, flashes the seven-segment
// display for a programmable hold time on each event, blanks it for one hold
// unit afterwards, then shows the current digit until the next event.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_SHOW  | display the BCD count digit, wait for a detection event
// S_FLASH | all segments lit for (N+1) hold units, N captured at the event
// S_GAP   | all segments dark for one hold unit, then back to S_SHOW
module tt_um_3515_detect_display_ctrl #(
   parameter int PRESCALE_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int TW = PRESCALE_W + 4;

   // One hold unit minus one: the value that makes the timer run 2^PRESCALE_W cycles.
   localparam logic [TW-1:0] GAP_LOAD = {4'b0000, {PRESCALE_W{1'b1}}};

   typedef enum logic [1:0] {
      S_SHOW  = 2'd0,
      S_FLASH = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   logic          det;
   logic          clr;
   logic          disp_en;
   logic [3:0]    hold_n;
   logic          unused_in;

   logic          det_r;
   logic          det_r2;
   logic          det_evt;

   state_t        state_q;
   state_t        state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic [TW-1:0] flash_load;
   logic [3:0]    count_q;
   logic          wrap_q;

   logic [7:0]    seg_target;
   logic [7:0]    uo_q;
   logic [3:0]    count_out;
   logic          flash_out;
   logic          wrap_out;

   assign det       = ui_in[0];
   assign clr       = ui_in[1];
   assign disp_en   = ui_in[2];
   assign hold_n    = ui_in[7:4];
   assign unused_in = ui_in[3];

   assign det_evt = det_r & ~det_r2;

   // (N+1)*2^P - 1 is simply N followed by P ones.
   assign flash_load = {hold_n, {PRESCALE_W{1'b1}}};

   // State register, hold timer, BCD counter and detector edge pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         det_r   <= 1'b0;
         det_r2  <= 1'b0;
         state_q <= S_SHOW;
         timer_q <= '0;
         count_q <= 4'd0;
         wrap_q  <= 1'b0;
      end else begin
         det_r  <= det;
         det_r2 <= det_r;
         if (clr) begin
            // A detection event coinciding with clr is dropped here.
            state_q <= S_SHOW;
            timer_q <= '0;
            count_q <= 4'd0;
            wrap_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (det_evt) begin
               if (count_q == 4'd9) begin
                  count_q <= 4'd0;
                  wrap_q  <= 1'b1;
               end else begin
                  count_q <= count_q + 4'd1;
               end
            end
         end
      end
   end

   // Next state and timer: an event always (re)starts the flash period.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (det_evt) begin
         state_d = S_FLASH;
         timer_d = flash_load;
      end else begin
         case (state_q)
            S_FLASH: begin
               if (timer_q == '0) begin
                  state_d = S_GAP;
                  timer_d = GAP_LOAD;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            S_GAP: begin
               if (timer_q == '0) begin
                  state_d = S_SHOW;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            S_SHOW: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: begin
               state_d = S_SHOW;
               timer_d = '0;
            end
         endcase
      end
   end

   // Segment target for the current state and digit.
   always_comb begin
      seg_target = 8'h00;
      case (state_q)
         S_SHOW: begin
            case (count_q)
               4'd0:    seg_target = 8'h3F;
               4'd1:    seg_target = 8'h06;
               4'd2:    seg_target = 8'h5B;
               4'd3:    seg_target = 8'h4F;
               4'd4:    seg_target = 8'h66;
               4'd5:    seg_target = 8'h6D;
               4'd6:    seg_target = 8'h7D;
               4'd7:    seg_target = 8'h07;
               4'd8:    seg_target = 8'h7F;
               4'd9:    seg_target = 8'h6F;
               default: seg_target = 8'h00;
            endcase
         end
         S_FLASH: seg_target = 8'hFF;
         S_GAP:   seg_target = 8'h00;
         default: seg_target = 8'h00;
      endcase
   end

   // Output registers; status bits are delayed one cycle to line up with the segments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uo_q      <= 8'h3F;
         count_out <= 4'd0;
         flash_out <= 1'b0;
         wrap_out  <= 1'b0;
      end else begin
         uo_q      <= disp_en ? seg_target : 8'h00;
         count_out <= count_q;
         flash_out <= (state_q == S_FLASH);
         wrap_out  <= wrap_q;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = {2'b00, wrap_out, flash_out, count_out};
   assign uio_oe  = 8'h3F;

endmodule

// File: tb/tb_tt_um_3515_detect_display_ctrl.sv
// Directed bench for the detection display controller (PRESCALE_W = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tt_um_3515_detect_display_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors;
   int miscompares;

   logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   tt_um_3515_detect_display_ctrl #(.PRESCALE_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle det pulse; returns at the negedge after the sampling edge.
   task automatic pulse_det();
      ui_in[0] = 1'b1;
      @(negedge clk);
      ui_in[0] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ui_in = 8'h05;
      repeat (3) @(negedge clk);
      vectors++;
      if (uo_out !== 8'h3F) begin
         miscompares++;
         $display("FAIL reset_uo_out got %h want 3f", uo_out);
      end
      vectors++;
      if (uio_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_uio_out got %h want 00", uio_out);
      end
      vectors++;
      if (uio_oe !== 8'h3F) begin
         miscompares++;
         $display("FAIL reset_uio_oe got %h want 3f", uio_oe);
      end
      ui_in = 8'h04;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (uo_out !== 8'h3F || uio_out !== 8'h00) begin
         miscompares++;
         $display("FAIL idle_after_reset got uo=%h uio=%h want 3f/00", uo_out, uio_out);
      end
   endtask

   task automatic test_single_flash();
      logic [7:0] exp;
      ui_in = 8'h04;
      ui_in[0] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) ui_in[0] = 1'b0;
         if (k < 2)       exp = 8'h3F;
         else if (k < 18) exp = 8'hFF;
         else if (k < 34) exp = 8'h00;
         else             exp = 8'h06;
         vectors++;
         if (uo_out !== exp) begin
            miscompares++;
            $display("FAIL single_flash k=%0d uo_out got %h want %h", k, uo_out, exp);
         end
         if (k == 2 || k == 17 || k == 18) begin
            vectors++;
            if (uio_out[4] !== (k != 18)) begin
               miscompares++;
               $display("FAIL single_flash_active k=%0d got %b want %b", k, uio_out[4], (k != 18));
            end
         end
      end
      vectors++;
      if (uio_out !== 8'h01) begin
         miscompares++;
         $display("FAIL single_count got %h want 01", uio_out);
      end
   endtask

   task automatic test_count_wrap();
      logic [7:0] exp_uio;
      ui_in = 8'h06;
      @(negedge clk);
      ui_in = 8'h04;
      repeat (2) @(negedge clk);
      vectors++;
      if (uio_out !== 8'h00 || uo_out !== 8'h3F) begin
         miscompares++;
         $display("FAIL wrap_pre_clr got uio=%h uo=%h want 00/3f", uio_out, uo_out);
      end
      for (int i = 1; i <= 10; i++) begin
         pulse_det();
         repeat (36) @(negedge clk);
         exp_uio = (i == 10) ? 8'h20 : 8'(i);
         vectors++;
         if (uio_out !== exp_uio) begin
            miscompares++;
            $display("FAIL wrap_count i=%0d uio_out got %h want %h", i, uio_out, exp_uio);
         end
         vectors++;
         if (uo_out !== seg_tab[i % 10]) begin
            miscompares++;
            $display("FAIL wrap_digit i=%0d uo_out got %h want %h", i, uo_out, seg_tab[i % 10]);
         end
      end
      ui_in[1] = 1'b1;
      @(negedge clk);
      ui_in[1] = 1'b0;
      @(negedge clk);
      vectors++;
      if (uio_out !== 8'h00 || uo_out !== 8'h3F) begin
         miscompares++;
         $display("FAIL wrap_clr got uio=%h uo=%h want 00/3f", uio_out, uo_out);
      end
   endtask

   task automatic test_held_and_retrigger();
      ui_in = 8'h04;
      ui_in[0] = 1'b1;
      repeat (100) @(negedge clk);
      ui_in[0] = 1'b0;
      repeat (40) @(negedge clk);
      vectors++;
      if (uio_out !== 8'h01) begin
         miscompares++;
         $display("FAIL held_det count got %h want 01", uio_out);
      end
      ui_in[7:4] = 4'd3;
      pulse_det();
      repeat (20) @(negedge clk);
      vectors++;
      if (uo_out !== 8'hFF) begin
         miscompares++;
         $display("FAIL retrig_first_flash got %h want ff", uo_out);
      end
      ui_in[0] = 1'b1;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (k == 0) ui_in[0] = 1'b0;
         if (k == 5) ui_in[7:4] = 4'd0;
         if (k >= 1 && k <= 65) begin
            vectors++;
            if (uo_out !== 8'hFF) begin
               miscompares++;
               $display("FAIL retrig_flash k=%0d uo_out got %h want ff", k, uo_out);
            end
         end
         if (k == 66) begin
            vectors++;
            if (uo_out !== 8'h00 || uio_out[4] !== 1'b0) begin
               miscompares++;
               $display("FAIL retrig_gap k=%0d got uo=%h fa=%b want 00/0", k, uo_out, uio_out[4]);
            end
         end
         if (k == 2) begin
            vectors++;
            if (uio_out[3:0] !== 4'd3) begin
               miscompares++;
               $display("FAIL retrig_count got %0d want 3", uio_out[3:0]);
            end
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_clr_priority();
      ui_in = 8'h04;
      ui_in[0] = 1'b1;
      @(negedge clk);
      ui_in[0] = 1'b0;
      ui_in[1] = 1'b1;
      @(negedge clk);
      ui_in[1] = 1'b0;
      for (int k = 2; k <= 20; k++) begin
         @(negedge clk);
         vectors++;
         if (uo_out !== 8'h3F || uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL clr_priority k=%0d got uo=%h uio=%h want 3f/00", k, uo_out, uio_out);
         end
      end
   endtask

   task automatic test_disp_en();
      logic [7:0] exp;
      ui_in = 8'h04;
      ui_in[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) ui_in[0] = 1'b0;
         if (k == 4) ui_in[2] = 1'b0;
         if (k == 8) ui_in[2] = 1'b1;
         if (k >= 2) begin
            exp = (k >= 5 && k <= 8) ? 8'h00 : 8'hFF;
            vectors++;
            if (uo_out !== exp || uio_out !== 8'h11) begin
               miscompares++;
               $display("FAIL disp_en k=%0d got uo=%h uio=%h want %h/11", k, uo_out, uio_out, exp);
            end
         end
      end
      repeat (40) @(negedge clk);
      vectors++;
      if (uo_out !== 8'h06) begin
         miscompares++;
         $display("FAIL disp_en_show got %h want 06", uo_out);
      end
   endtask

   task automatic test_reset_mid_gap();
      ui_in = 8'h04;
      ui_in[0] = 1'b1;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (k == 0) ui_in[0] = 1'b0;
         if (k == 22) rst_n = 1'b0;
         if (k == 23) rst_n = 1'b1;
         vectors++;
         if (uio_oe !== 8'h3F) begin
            miscompares++;
            $display("FAIL rst_gap_oe k=%0d got %h want 3f", k, uio_oe);
         end
         if (k == 20) begin
            vectors++;
            if (uo_out !== 8'h00) begin
               miscompares++;
               $display("FAIL rst_gap_pre got %h want 00", uo_out);
            end
         end
         if (k >= 23) begin
            vectors++;
            if (uo_out !== 8'h3F || uio_out !== 8'h00) begin
               miscompares++;
               $display("FAIL rst_gap k=%0d got uo=%h uio=%h want 3f/00", k, uo_out, uio_out);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      ui_in       = 8'h00;
      @(negedge clk);
      test_reset();
      test_single_flash();
      test_count_wrap();
      test_held_and_retrigger();
      test_clr_priority();
      test_disp_en();
      test_reset_mid_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
